serial_magnitude_compare: RTL and testbench
===========================================

Name: serial_magnitude_compare

Overview:
- Multi-cycle, parametrised successor to the team's 4-bit combinational comparator.
- Compares two W-bit operands MSB-first, D bits per clock.
- Supports unsigned or two's-complement mode, with optional early exit at the first differing digit.
- Produces the established 6-bit relation vector: eq, ne, gt, lt, ge, le. Used where wide operands make a flat comparator too slow or too large.

Parameters:
- W, 16, operand width in bits; must be a multiple of D.
- D, 4, digit width compared per cycle; NDIG = W/D.
- EARLY_EXIT, 0, 1 = finish at the first differing digit; 0 = always run NDIG cycles (fixed latency).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare; latched with start.
- a  input  W  operand A; latched with start.
- b  input  W  operand B; latched with start.
- busy  output  1  high while a compare is in progress (RUN).
- done  output  1  one-cycle pulse; y is newly valid.
- y  output  6  y[5]=eq, y[4]=ne, y[3]=gt, y[2]=lt, y[1]=ge, y[0]=le.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, y=6'b000000, shift registers and result flags cleared. Applying rst in RUN or DONE aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start=1. That edge latches a, b, signed_mode into shift registers, clears the digit counter, and clears the decided/gt/lt flags.
- RUN, each edge: compare the top D bits of sa and sb.
  - On digit 0 with signed_mode=1, invert the MSB of both digits before comparing. This orders negative values below non-negative ones.
  - If not yet decided and the digits differ: set decided, and set gt or lt from the digit magnitude.
  - Once decided, the flags are frozen; later digits are ignored.
  - Shift sa and sb left by D and increment the counter.
- RUN -> DONE on the edge that processes the last digit (counter = NDIG-1), or, when EARLY_EXIT=1, on the edge where the first difference is found.
  - That same edge registers y from the final flags: eq=~decided, ne=decided, gt, lt, ge=gt|eq, le=lt|eq.
- DONE -> IDLE unconditionally after one cycle.
- Outputs by state: done=1 only in DONE; busy=1 only in RUN.
- y holds its value until the next DONE or until reset.
- Latency: start sampled at edge t gives done high in the cycle after edge t+N.
  - EARLY_EXIT=0: N=NDIG.
  - EARLY_EXIT=1: N = 1-based index of the first differing digit, or NDIG if the operands are equal.
- start while in RUN or DONE is ignored; operand changes after latching have no effect.
- Exactly one of eq/ne is set, and at most one of gt/lt. Unsigned and signed results are identical when the operand MSBs match.
- Elaboration check: W % D != 0 is an elaboration error.

Decomposition:
- Shared package:
  - state encoding (IDLE/RUN/DONE).
  - flag index constants FLAG_EQ=5, FLAG_NE=4, FLAG_GT=3, FLAG_LT=2, FLAG_GE=1, FLAG_LE=0.
  - a function mapping (decided, gt, lt) to the 6-bit vector.
- One sub-module, digit_cmp: combinational D-bit compare with an msb_invert input, outputs dgt/dlt.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- W=8, D=2, EARLY_EXIT=0, unsigned, a=8'h5A, b=8'h5A, start one cycle -> busy for 4 cycles, then done pulse, y=6'b100011.
- Same configuration, a=8'h80, b=8'h7F -> y=6'b011010 (gt) after 4 cycles. Repeat with signed_mode=1 -> y=6'b010101 (lt).
- EARLY_EXIT=1, a=8'hC0, b=8'h00, unsigned -> done after 1 cycle, y=6'b011010. Repeat with signed_mode=1 -> y=6'b010101. Repeat with a=b=8'h00 -> done after 4 cycles, y=6'b100011.
- start pulsed again 2 cycles into RUN with a different a/b -> ignored; result reflects the first operands and exactly one done pulse occurs.
- rst asserted mid-RUN (cycle 2) -> busy, done and y go to 0 immediately, with no done pulse. A fresh start then completes normally with correct y.
- Random sweep, W=16, D=4, both modes and both EARLY_EXIT settings -> y matches reference relations; done spacing matches the latency rule.

Source files
------------

// File: rtl/serial_magnitude_compare_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_magnitude_compare_pkg;

  // Relation vector width and bit positions.
  localparam int unsigned Y_W     = 6;
  localparam int unsigned FLAG_EQ = 5;
  localparam int unsigned FLAG_NE = 4;
  localparam int unsigned FLAG_GT = 3;
  localparam int unsigned FLAG_LT = 2;
  localparam int unsigned FLAG_GE = 1;
  localparam int unsigned FLAG_LE = 0;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Build the relation vector from the final decision flags.
  function automatic logic [Y_W-1:0] flags_to_y(input logic decided,
                                                 input logic gt,
                                                 input logic lt);
    logic [Y_W-1:0] v;
    logic           eq;
    eq          = ~decided;
    v           = '0;
    v[FLAG_EQ]  = eq;
    v[FLAG_NE]  = decided;
    v[FLAG_GT]  = gt;
    v[FLAG_LT]  = lt;
    v[FLAG_GE]  = gt | eq;
    v[FLAG_LE]  = lt | eq;
    return v;
  endfunction

endpackage

// File: rtl/serial_magnitude_compare_digit_cmp.sv
// Combinational D-bit digit compare; msb_invert maps two's-complement
// sign ordering onto an unsigned compare for the most significant digit.
module serial_magnitude_compare_digit_cmp #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         msb_invert,
  output logic         dgt,
  output logic         dlt
);

  logic [D-1:0] mask;
  logic [D-1:0] ax;
  logic [D-1:0] bx;

  // Flip the sign bit of both digits when requested, then compare unsigned.
  always_comb begin
    mask        = '0;
    mask[D-1]   = msb_invert;
    ax          = a ^ mask;
    bx          = b ^ mask;
    dgt         = (ax > bx);
    dlt         = (ax < bx);
  end

endmodule

// File: rtl/serial_magnitude_compare.sv
// Multi-cycle MSB-first magnitude comparator, D bits per clock, with
// optional signed mode and optional early exit at the first differing digit.
module serial_magnitude_compare
  import serial_magnitude_compare_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned D          = 4,
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [Y_W-1:0] y
);

  localparam int unsigned NDIG  = W / D;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((W % D) != 0) begin : g_width_check
    $error("serial_magnitude_compare: W must be a multiple of D");
  end

  state_e           state_q;
  state_e           state_d;
  logic [W-1:0]     sa_q;
  logic [W-1:0]     sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sm_q;
  logic             decided_q;
  logic             gt_q;
  logic             lt_q;

  logic             dgt;
  logic             dlt;
  logic             diff;
  logic             decided_n;
  logic             gt_n;
  logic             lt_n;
  logic             last_digit;
  logic             run_exit;

  logic             load_c;
  logic             step_c;
  logic             busy_d;
  logic             done_d;

  // Compare the current top digit of both shift registers.
  serial_magnitude_compare_digit_cmp #(
    .D (D)
  ) u_digit_cmp (
    .a          (sa_q[W-1 -: D]),
    .b          (sb_q[W-1 -: D]),
    .msb_invert (sm_q && (cnt_q == '0)),
    .dgt        (dgt),
    .dlt        (dlt)
  );

  // First difference wins; later digits cannot change a decided result.
  assign diff       = dgt | dlt;
  assign decided_n  = decided_q | diff;
  assign gt_n       = decided_q ? gt_q : dgt;
  assign lt_n       = decided_q ? lt_q : dlt;
  assign last_digit = (cnt_q == LAST_DIG);
  assign run_exit   = last_digit || ((EARLY_EXIT != 0) && !decided_q && diff);

  // State register plus registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (run_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes and next values of the status outputs.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    load_c = (state_q == IDLE) && start;
    step_c = (state_q == RUN);
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Operand shift registers, digit counter, decision flags and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      sm_q      <= 1'b0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      y         <= '0;
    end else if (load_c) begin
      sa_q      <= a;
      sb_q      <= b;
      cnt_q     <= '0;
      sm_q      <= signed_mode;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else if (step_c) begin
      sa_q      <= sa_q << D;
      sb_q      <= sb_q << D;
      cnt_q     <= cnt_q + CNT_W'(1);
      decided_q <= decided_n;
      gt_q      <= gt_n;
      lt_q      <= lt_n;
      if (run_exit) y <= flags_to_y(decided_n, gt_n, lt_n);
    end
  end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Directed bench: 8-bit D=2 instances (fixed latency and early exit) and
// 16-bit D=4 instances for a wider sweep against a behavioural reference.
module tb_serial_magnitude_compare;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic        sm = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;

  wire  [3:0]  busy_w;
  wire  [3:0]  done_w;
  wire  [5:0]  y0, y1, y2, y3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_compare #(.W(8), .D(2), .EARLY_EXIT(0)) u_fix8 (
    .clk(clk), .rst(rst), .start(start[0]), .signed_mode(sm),
    .a(a8), .b(b8), .busy(busy_w[0]), .done(done_w[0]), .y(y0));

  serial_magnitude_compare #(.W(8), .D(2), .EARLY_EXIT(1)) u_ee8 (
    .clk(clk), .rst(rst), .start(start[1]), .signed_mode(sm),
    .a(a8), .b(b8), .busy(busy_w[1]), .done(done_w[1]), .y(y1));

  serial_magnitude_compare #(.W(16), .D(4), .EARLY_EXIT(0)) u_fix16 (
    .clk(clk), .rst(rst), .start(start[2]), .signed_mode(sm),
    .a(a16), .b(b16), .busy(busy_w[2]), .done(done_w[2]), .y(y2));

  serial_magnitude_compare #(.W(16), .D(4), .EARLY_EXIT(1)) u_ee16 (
    .clk(clk), .rst(rst), .start(start[3]), .signed_mode(sm),
    .a(a16), .b(b16), .busy(busy_w[3]), .done(done_w[3]), .y(y3));

  function automatic logic [5:0] ysel(input int idx);
    case (idx)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  // Launch one compare on instance idx and observe latency, busy cycles,
  // result and number of done pulses (lat = -1 when done never arrives).
  task automatic run_cmp(input int idx, input logic s,
                         input logic [15:0] av, input logic [15:0] bv,
                         output int lat, output int busy_cnt,
                         output logic [5:0] yv, output int pulses);
    @(posedge clk); #1;
    sm = s; a8 = av[7:0]; b8 = bv[7:0]; a16 = av; b16 = bv;
    start[idx] = 1'b1;
    @(posedge clk); #1;
    start[idx] = 1'b0;
    lat = -1; busy_cnt = 0; pulses = 0; yv = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_w[idx]) begin
        lat = n - 1; yv = ysel(idx); pulses = 1;
        break;
      end
      if (busy_w[idx]) busy_cnt++;
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done_w[idx]) pulses++;
    end
  endtask

  function automatic logic [5:0] ref_y(input logic s, input logic [15:0] av,
                                       input logic [15:0] bv);
    logic eq, gt, lt;
    eq = (av == bv);
    gt = s ? ($signed(av) > $signed(bv)) : (av > bv);
    lt = s ? ($signed(av) < $signed(bv)) : (av < bv);
    return {eq, ~eq, gt, lt, gt | eq, lt | eq};
  endfunction

  function automatic int ref_lat16(input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] x;
    x = av ^ bv;
    for (int i = 0; i < 4; i++)
      if (x[15 - 4*i -: 4] != 4'h0) return i + 1;
    return 4;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy_w !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", busy_w); end
    checks++;
    if (done_w !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done_w); end
    checks++;
    if ({y0, y1, y2, y3} !== 24'h0) begin
      errors++; $display("FAIL reset_y got %h want 000000", {y0, y1, y2, y3});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_w !== 4'b0000 || done_w !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset busy %b done %b want 0000/0000", busy_w, done_w);
    end
  endtask

  // idx, signed, a, b, expected y, expected latency
  task automatic test_vectors8(input string name, input int idx);
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vs [3];
    logic [5:0] vy [3];
    int         vl [3];
    int lat, bc, pulses;
    logic [5:0] yv;
    if (idx == 0) begin
      va = '{8'h5A, 8'h80, 8'h80}; vb = '{8'h5A, 8'h7F, 8'h7F};
      vs = '{1'b0, 1'b0, 1'b1};
      vy = '{6'b100011, 6'b011010, 6'b010101};
      vl = '{4, 4, 4};
    end else begin
      va = '{8'hC0, 8'hC0, 8'h00}; vb = '{8'h00, 8'h00, 8'h00};
      vs = '{1'b0, 1'b1, 1'b0};
      vy = '{6'b011010, 6'b010101, 6'b100011};
      vl = '{1, 1, 4};
    end
    for (int i = 0; i < 3; i++) begin
      run_cmp(idx, vs[i], {8'h00, va[i]}, {8'h00, vb[i]}, lat, bc, yv, pulses);
      checks++;
      if (yv !== vy[i]) begin errors++; $display("FAIL %s_%0d_y got %b want %b", name, i, yv, vy[i]); end
      checks++;
      if (lat != vl[i]) begin errors++; $display("FAIL %s_%0d_latency got %0d want %0d", name, i, lat, vl[i]); end
      checks++;
      if (bc != vl[i]) begin errors++; $display("FAIL %s_%0d_busy_cycles got %0d want %0d", name, i, bc, vl[i]); end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL %s_%0d_done_pulses got %0d want 1", name, i, pulses); end
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [5:0] yv;
    @(posedge clk); #1;
    sm = 1'b0; a8 = 8'h12; b8 = 8'h34; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h00; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    pulses = 0; yv = 'x;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done_w[0]) begin pulses++; yv = y0; end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", pulses); end
    checks++;
    if (yv !== 6'b010101) begin errors++; $display("FAIL restart_y got %b want 010101", yv); end
  endtask

  task automatic test_reset_abort();
    int pulses, lat, bc;
    logic [5:0] yv;
    @(posedge clk); #1;
    sm = 1'b0; a8 = 8'h01; b8 = 8'h02; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy_w[0]); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      errors++; $display("FAIL abort_status busy %b done %b want 0/0", busy_w[0], done_w[0]);
    end
    checks++;
    if (y0 !== 6'b000000) begin errors++; $display("FAIL abort_y got %b want 000000", y0); end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_w[0]) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", pulses); end
    run_cmp(0, 1'b1, 16'h009C, 16'h009C, lat, bc, yv, pulses);
    checks++;
    if (yv !== 6'b100011 || lat != 4) begin
      errors++; $display("FAIL abort_restart y %b lat %0d want 100011 lat 4", yv, lat);
    end
  endtask

  task automatic test_sweep16();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] av, bv;
    logic [5:0]  yv, ye;
    int lat, bc, pulses, le;
    va = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0001, 16'h1230, 16'hA5A5, 16'h7FFF, 16'h0F00};
    vb = '{16'h1234, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h1234, 16'hA5A4, 16'h8000, 16'h0E00};
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        av = va[i]; bv = vb[i];
      end else begin
        av = 16'($urandom);
        bv = (i == 13) ? av : 16'($urandom);
      end
      for (int s = 0; s < 2; s++) begin
        ye = ref_y(s[0], av, bv);
        for (int idx = 2; idx < 4; idx++) begin
          le = (idx == 3) ? ref_lat16(av, bv) : 4;
          run_cmp(idx, s[0], av, bv, lat, bc, yv, pulses);
          checks++;
          if (yv !== ye) begin
            errors++; $display("FAIL sweep_y inst %0d s %0d a %h b %h got %b want %b", idx, s, av, bv, yv, ye);
          end
          checks++;
          if (lat != le) begin
            errors++; $display("FAIL sweep_latency inst %0d a %h b %h got %0d want %0d", idx, av, bv, lat, le);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors8("fixed8", 0);
    test_vectors8("early8", 1);
    test_start_ignored();
    test_reset_abort();
    test_sweep16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
